// File: rtl/core_uart_ctrl.sv
// AXI4-Lite master that polls the UART Lite status register, then moves one byte to/from its FIFO.
// Read completes 5 cycles after accept with a ready slave; each not-ready poll adds POLL_GAP+2; VALIDs are held until their handshake.
module core_uart_ctrl #(
  parameter int POLL_GAP = 4
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        IN_REQ,
  input  logic        OUT_REQ,
  input  logic [7:0]  OUT_DATA,
  output logic        BUSY,
  output logic        DONE,
  output logic        ERR,
  output logic [7:0]  IN_DATA,
  output logic [3:0]  ARADDR,
  output logic        ARVALID,
  input  logic        ARREADY,
  input  logic [31:0] RDATA,
  input  logic [1:0]  RRESP,
  input  logic        RVALID,
  output logic        RREADY,
  output logic [3:0]  AWADDR,
  output logic        AWVALID,
  input  logic        AWREADY,
  output logic [31:0] WDATA,
  output logic [3:0]  WSTRB,
  output logic        WVALID,
  input  logic        WREADY,
  input  logic [1:0]  BRESP,
  input  logic        BVALID,
  output logic        BREADY
);

  typedef enum logic [3:0] {IDLE, ST_AR, ST_R, GAP, DAT_AR, DAT_R, TX_AW, TX_B, FIN} state_t;

  localparam logic [3:0] ADDR_RX   = 4'h0;
  localparam logic [3:0] ADDR_TX   = 4'h4;
  localparam logic [3:0] ADDR_STAT = 4'h8;
  localparam logic [7:0] GAP_LOAD  = (POLL_GAP > 0) ? 8'(POLL_GAP - 1) : 8'd0;

  state_t      state, state_nxt;
  logic        op_rd, op_rd_nxt;
  logic [7:0]  tx_byte, tx_byte_nxt;
  logic [7:0]  gap_cnt, gap_cnt_nxt;
  logic        busy_nxt, done_nxt, err_nxt;
  logic [7:0]  in_data_nxt;
  logic [3:0]  araddr_nxt, awaddr_nxt;
  logic        arvalid_nxt, rready_nxt, awvalid_nxt, wvalid_nxt, bready_nxt;
  logic [31:0] wdata_nxt;
  logic [3:0]  wstrb_nxt;
  logic        stat_ready;
  logic        unused_rdata;

  // RX path waits for "RX valid"; TX path waits for "TX full" to clear.
  assign stat_ready   = op_rd ? RDATA[0] : ~RDATA[3];
  assign unused_rdata = ^RDATA[31:8];

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state   <= IDLE;
      op_rd   <= 1'b0;
      tx_byte <= 8'h00;
      gap_cnt <= 8'h00;
      BUSY    <= 1'b0;
      DONE    <= 1'b0;
      ERR     <= 1'b0;
      IN_DATA <= 8'h00;
      ARADDR  <= 4'h0;
      ARVALID <= 1'b0;
      RREADY  <= 1'b0;
      AWADDR  <= 4'h0;
      AWVALID <= 1'b0;
      WDATA   <= 32'h0;
      WSTRB   <= 4'h0;
      WVALID  <= 1'b0;
      BREADY  <= 1'b0;
    end else begin
      state   <= state_nxt;
      op_rd   <= op_rd_nxt;
      tx_byte <= tx_byte_nxt;
      gap_cnt <= gap_cnt_nxt;
      BUSY    <= busy_nxt;
      DONE    <= done_nxt;
      ERR     <= err_nxt;
      IN_DATA <= in_data_nxt;
      ARADDR  <= araddr_nxt;
      ARVALID <= arvalid_nxt;
      RREADY  <= rready_nxt;
      AWADDR  <= awaddr_nxt;
      AWVALID <= awvalid_nxt;
      WDATA   <= wdata_nxt;
      WSTRB   <= wstrb_nxt;
      WVALID  <= wvalid_nxt;
      BREADY  <= bready_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    op_rd_nxt   = op_rd;
    tx_byte_nxt = tx_byte;
    gap_cnt_nxt = gap_cnt;
    done_nxt    = 1'b0;
    err_nxt     = 1'b0;
    in_data_nxt = IN_DATA;
    araddr_nxt  = ARADDR;
    arvalid_nxt = ARVALID;
    rready_nxt  = RREADY;
    awaddr_nxt  = AWADDR;
    awvalid_nxt = AWVALID;
    wdata_nxt   = WDATA;
    wstrb_nxt   = WSTRB;
    wvalid_nxt  = WVALID;
    bready_nxt  = BREADY;

    case (state)
      IDLE: begin
        if (IN_REQ || OUT_REQ) begin
          op_rd_nxt = IN_REQ;
          if (!IN_REQ) tx_byte_nxt = OUT_DATA;
          araddr_nxt  = ADDR_STAT;
          arvalid_nxt = 1'b1;
          state_nxt   = ST_AR;
        end
      end
      ST_AR, DAT_AR: begin
        if (ARVALID && ARREADY) begin
          arvalid_nxt = 1'b0;
          rready_nxt  = 1'b1;
          state_nxt   = (state == ST_AR) ? ST_R : DAT_R;
        end
      end
      ST_R: begin
        if (RVALID && RREADY) begin
          rready_nxt = 1'b0;
          if (RRESP != 2'b00) begin
            err_nxt   = 1'b1;
            done_nxt  = 1'b1;
            state_nxt = FIN;
          end else if (stat_ready && op_rd) begin
            araddr_nxt  = ADDR_RX;
            arvalid_nxt = 1'b1;
            state_nxt   = DAT_AR;
          end else if (stat_ready) begin
            awaddr_nxt  = ADDR_TX;
            awvalid_nxt = 1'b1;
            wdata_nxt   = {24'h0, tx_byte};
            wstrb_nxt   = 4'b0001;
            wvalid_nxt  = 1'b1;
            state_nxt   = TX_AW;
          end else if (POLL_GAP == 0) begin
            araddr_nxt  = ADDR_STAT;
            arvalid_nxt = 1'b1;
            state_nxt   = ST_AR;
          end else begin
            gap_cnt_nxt = GAP_LOAD;
            state_nxt   = GAP;
          end
        end
      end
      GAP: begin
        if (gap_cnt == 8'd0) begin
          araddr_nxt  = ADDR_STAT;
          arvalid_nxt = 1'b1;
          state_nxt   = ST_AR;
        end else begin
          gap_cnt_nxt = gap_cnt - 8'd1;
        end
      end
      DAT_R: begin
        if (RVALID && RREADY) begin
          rready_nxt = 1'b0;
          if (RRESP == 2'b00) in_data_nxt = RDATA[7:0];
          else                err_nxt     = 1'b1;
          done_nxt  = 1'b1;
          state_nxt = FIN;
        end
      end
      TX_AW: begin
        // AW and W retire independently; move on once neither is still pending.
        if (AWVALID && AWREADY) awvalid_nxt = 1'b0;
        if (WVALID && WREADY) begin
          wvalid_nxt = 1'b0;
          wstrb_nxt  = 4'h0;
        end
        if (!awvalid_nxt && !wvalid_nxt) begin
          bready_nxt = 1'b1;
          state_nxt  = TX_B;
        end
      end
      TX_B: begin
        if (BVALID && BREADY) begin
          bready_nxt = 1'b0;
          err_nxt    = (BRESP != 2'b00);
          done_nxt   = 1'b1;
          state_nxt  = FIN;
        end
      end
      FIN:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase

    busy_nxt = (state_nxt != IDLE) && (state_nxt != FIN);
  end

endmodule

// File: tb/tb_core_uart_ctrl.sv
// Bench for core_uart_ctrl: AXI4-Lite UART Lite slave model driven on the falling edge, expectations from timing rules.
module tb_core_uart_ctrl;
  localparam int G = 4;

  logic        CLK = 1'b0;
  logic        RST_N = 1'b0;
  logic        IN_REQ = 1'b0, OUT_REQ = 1'b0;
  logic [7:0]  OUT_DATA = 8'h00;
  logic        BUSY, DONE, ERR;
  logic [7:0]  IN_DATA;
  logic [3:0]  ARADDR, AWADDR;
  logic        ARVALID, RREADY, AWVALID, WVALID, BREADY;
  logic        ARREADY = 1'b1, AWREADY = 1'b0, WREADY = 1'b0;
  logic [31:0] RDATA = 32'h0, WDATA;
  logic [1:0]  RRESP = 2'b00, BRESP = 2'b00;
  logic        RVALID = 1'b0, BVALID = 1'b0;
  logic [3:0]  WSTRB;

  core_uart_ctrl #(.POLL_GAP(G)) dut (
    .CLK(CLK), .RST_N(RST_N), .IN_REQ(IN_REQ), .OUT_REQ(OUT_REQ), .OUT_DATA(OUT_DATA),
    .BUSY(BUSY), .DONE(DONE), .ERR(ERR), .IN_DATA(IN_DATA),
    .ARADDR(ARADDR), .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RDATA(RDATA), .RRESP(RRESP), .RVALID(RVALID), .RREADY(RREADY),
    .AWADDR(AWADDR), .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WDATA(WDATA), .WSTRB(WSTRB), .WVALID(WVALID), .WREADY(WREADY),
    .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY)
  );

  always #5 CLK = ~CLK;
  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  // slave configuration and transaction logs
  logic [33:0] status_q[$];
  logic [7:0]  rx_byte = 8'h00;
  logic [1:0]  rx_resp = 2'b00, b_resp = 2'b00;
  int          aw_delay = 0, w_delay = 0;
  logic [3:0]  ar_addr_q[$];
  logic [31:0] w_data_q[$];
  logic [3:0]  w_strb_q[$];
  logic [3:0]  last_awaddr = 4'h0;
  int          ar_rise_q[$], rhs_q[$];
  int          b_cnt = 0, status_reads = 0, first_rready = -1, wv_fall = -1, aw_fall = -1;
  bit          strb_bad = 0;
  bit          p_ar, p_r, p_aw, p_w, p_b, got_aw, got_w;
  bit          prev_arvalid, prev_rready, prev_wvalid, prev_awvalid;
  logic [3:0]  p_araddr, p_awaddr, p_wstrb;
  logic [31:0] p_wdata;
  int          aw_cnt = 0, w_cnt = 0;

  int          n_cmp = 0, n_fail = 0;
  int          k, done_at;
  logic        err_seen;
  logic [7:0]  in_mdl = 8'h00;

  // p_* flags hold what the last rising edge saw, so responses appear in the following cycle.
  always @(negedge CLK) begin
    if (!RST_N) begin
      RVALID = 0; BVALID = 0; AWREADY = 0; WREADY = 0; RDATA = 0; RRESP = 0; BRESP = 0;
      p_ar = 0; p_r = 0; p_aw = 0; p_w = 0; p_b = 0; got_aw = 0; got_w = 0;
      prev_arvalid = 0; prev_rready = 0; prev_wvalid = 0; prev_awvalid = 0;
      aw_cnt = 0; w_cnt = 0;
    end else begin
      if (p_r) begin RVALID = 0; rhs_q.push_back(cyc); end
      if (p_ar) begin
        ar_addr_q.push_back(p_araddr);
        if (p_araddr == 4'h8) begin
          status_reads++;
          if (status_q.size() > 0) {RRESP, RDATA} = status_q.pop_front();
          else {RRESP, RDATA} = 34'h0;
        end else begin
          RDATA = $urandom();
          RDATA[7:0] = rx_byte;
          RRESP = rx_resp;
        end
        RVALID = 1;
      end
      if (p_aw) begin got_aw = 1; last_awaddr = p_awaddr; end
      if (p_w) begin got_w = 1; w_data_q.push_back(p_wdata); w_strb_q.push_back(p_wstrb); end
      if (p_b) begin BVALID = 0; b_cnt++; end
      if (got_aw && got_w) begin BVALID = 1; BRESP = b_resp; got_aw = 0; got_w = 0; end
      if (AWVALID) begin AWREADY = (aw_cnt >= aw_delay); aw_cnt++; end
      else begin AWREADY = 0; aw_cnt = 0; end
      if (WVALID) begin WREADY = (w_cnt >= w_delay); w_cnt++; end
      else begin WREADY = 0; w_cnt = 0; end
      if (ARVALID && !prev_arvalid) ar_rise_q.push_back(cyc + 1);
      if (RREADY && !prev_rready && first_rready < 0) first_rready = cyc + 1;
      if (prev_wvalid && !WVALID) wv_fall = cyc + 1;
      if (prev_awvalid && !AWVALID) aw_fall = cyc + 1;
      if (WSTRB !== (WVALID ? 4'b0001 : 4'b0000)) strb_bad = 1;
      prev_arvalid = ARVALID; prev_rready = RREADY; prev_wvalid = WVALID; prev_awvalid = AWVALID;
      p_ar = ARVALID && ARREADY; p_araddr = ARADDR;
      p_r = RVALID && RREADY;
      p_aw = AWVALID && AWREADY; p_awaddr = AWADDR;
      p_w = WVALID && WREADY; p_wdata = WDATA; p_wstrb = WSTRB;
      p_b = BVALID && BREADY;
    end
  end

  task automatic clear_logs();
    ar_addr_q.delete(); w_data_q.delete(); w_strb_q.delete(); ar_rise_q.delete(); rhs_q.delete();
    status_q.delete();
    b_cnt = 0; status_reads = 0; first_rready = -1; wv_fall = -1; aw_fall = -1; strb_bad = 0;
  endtask

  task automatic start_req(input bit rd, input bit wr, input logic [7:0] b);
    @(negedge CLK); #1;
    IN_REQ = rd; OUT_REQ = wr; OUT_DATA = b;
    k = cyc + 1;
  endtask

  task automatic wait_done(input bit drop_in, input bit drop_out, input bit scramble);
    done_at = -1;
    for (int i = 0; i < 1000; i++) begin
      @(negedge CLK); #1;
      if (i == 0 && scramble) OUT_DATA = 8'($urandom());
      if (DONE) begin
        done_at = cyc + 1; err_seen = ERR;
        if (drop_in) IN_REQ = 0;
        if (drop_out) OUT_REQ = 0;
        break;
      end
    end
    if (done_at < 0) begin IN_REQ = 0; OUT_REQ = 0; end
  endtask

  task automatic test_reset();
    RST_N = 0;
    repeat (3) @(negedge CLK);
    #1;
    n_cmp++;
    if ({BUSY, DONE, ERR, IN_DATA, ARVALID, RREADY, AWVALID, WVALID, BREADY, ARADDR, AWADDR, WDATA, WSTRB} !== 60'h0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %h required 0",
               {BUSY, DONE, ERR, IN_DATA, ARVALID, RREADY, AWVALID, WVALID, BREADY, ARADDR, AWADDR, WDATA, WSTRB});
    end
    RST_N = 1;
    repeat (2) @(negedge CLK);
    #1;
    n_cmp++;
    if ({BUSY, DONE, ARVALID, AWVALID, WVALID} !== 5'b0) begin
      n_fail++; $display("FAIL idle_after_reset: got %b required 00000", {BUSY, DONE, ARVALID, AWVALID, WVALID});
    end
  endtask

  task automatic test_read_basic();
    clear_logs();
    status_q.push_back({2'b00, 32'h1});
    rx_byte = 8'h41; rx_resp = 2'b00;
    start_req(1, 0, 8'h00);
    wait_done(1, 1, 1);
    in_mdl = 8'h41;
    n_cmp++;
    if (done_at != k + 5) begin n_fail++; $display("FAIL rd_done_cycle: got %0d required %0d", done_at - k, 5); end
    n_cmp++;
    if (err_seen !== 1'b0) begin n_fail++; $display("FAIL rd_err: got %b required 0", err_seen); end
    n_cmp++;
    if (IN_DATA !== in_mdl) begin n_fail++; $display("FAIL rd_in_data: got %h required %h", IN_DATA, in_mdl); end
    n_cmp++;
    if (ar_addr_q.size() != 2 || ar_addr_q[0] != 4'h8 || ar_addr_q[1] != 4'h0) begin
      n_fail++; $display("FAIL rd_ar_seq: got %0d transactions required 2 (8,0)", ar_addr_q.size());
    end
    n_cmp++;
    if (ar_rise_q.size() < 1 || ar_rise_q[0] != k + 1) begin n_fail++; $display("FAIL rd_arvalid_start: required k+1"); end
    n_cmp++;
    if (first_rready != k + 2) begin n_fail++; $display("FAIL rd_rready_start: got k+%0d required k+2", first_rready - k); end
    @(negedge CLK); #1;
    n_cmp++;
    if ({DONE, BUSY} !== 2'b00) begin n_fail++; $display("FAIL rd_idle_after: got %b required 00", {DONE, BUSY}); end
  endtask

  task automatic test_read_poll();
    clear_logs();
    for (int j = 0; j < 3; j++) status_q.push_back({2'b00, 32'($urandom()) & ~32'h1});
    status_q.push_back({2'b00, 32'h1});
    rx_byte = 8'($urandom()); rx_resp = 2'b00;
    start_req(1, 0, 8'h00);
    wait_done(1, 1, 1);
    in_mdl = rx_byte;
    n_cmp++;
    if (done_at != k + 23) begin n_fail++; $display("FAIL poll_done_cycle: got k+%0d required k+23", done_at - k); end
    n_cmp++;
    if (status_reads != 4) begin n_fail++; $display("FAIL poll_status_reads: got %0d required 4", status_reads); end
    n_cmp++;
    if (IN_DATA !== in_mdl) begin n_fail++; $display("FAIL poll_in_data: got %h required %h", IN_DATA, in_mdl); end
    if (ar_rise_q.size() < 4 || rhs_q.size() < 3) begin
      n_cmp++; n_fail++; $display("FAIL poll_gap_log: got %0d polls required 4", ar_rise_q.size());
    end else begin
      for (int j = 0; j < 3; j++) begin
        n_cmp++;
        if (ar_rise_q[j + 1] - rhs_q[j] - 1 != G) begin
          n_fail++; $display("FAIL poll_gap%0d: got %0d required %0d", j, ar_rise_q[j + 1] - rhs_q[j] - 1, G);
        end
      end
    end
  endtask

  task automatic test_write_delay();
    clear_logs();
    status_q.push_back({2'b00, 32'h8});
    status_q.push_back({2'b00, 32'h0});
    aw_delay = 3; w_delay = 0; b_resp = 2'b00;
    start_req(0, 1, 8'h5A);
    wait_done(1, 1, 1);
    n_cmp++;
    if (done_at != k + 5 + (G + 2) + 3) begin n_fail++; $display("FAIL wr_done_cycle: got k+%0d required k+%0d", done_at - k, 5 + G + 2 + 3); end
    n_cmp++;
    if (err_seen !== 1'b0) begin n_fail++; $display("FAIL wr_err: got %b required 0", err_seen); end
    n_cmp++;
    if (w_data_q.size() != 1 || w_data_q[0] != 32'h5A || w_strb_q[0] != 4'b0001) begin
      n_fail++; $display("FAIL wr_wdata: got %0d beats required one beat 0000005a/1", w_data_q.size());
    end
    n_cmp++;
    if (last_awaddr !== 4'h4) begin n_fail++; $display("FAIL wr_awaddr: got %h required 4", last_awaddr); end
    n_cmp++;
    if (!(wv_fall >= 0 && wv_fall < aw_fall)) begin n_fail++; $display("FAIL wr_drop_order: got w=%0d aw=%0d required w<aw", wv_fall, aw_fall); end
    n_cmp++;
    if (b_cnt != 1) begin n_fail++; $display("FAIL wr_b_count: got %0d required 1", b_cnt); end
    n_cmp++;
    if (strb_bad) begin n_fail++; $display("FAIL wr_wstrb_gating: got stray WSTRB required 1 only with WVALID"); end
    aw_delay = 0;
  endtask

  task automatic test_back_to_back();
    logic [7:0] b;
    int d1;
    clear_logs();
    status_q.push_back({2'b00, 32'h1});
    status_q.push_back({2'b00, 32'h1});
    rx_byte = 8'($urandom()); rx_resp = 2'b00; b = 8'($urandom()); b_resp = 2'b00;
    start_req(1, 1, b);
    wait_done(1, 0, 0);
    d1 = done_at;
    in_mdl = rx_byte;
    n_cmp++;
    if (d1 != k + 5 || ar_addr_q.size() != 2 || ar_addr_q[1] != 4'h0) begin
      n_fail++; $display("FAIL b2b_read_first: got done k+%0d, %0d AR required k+5, 2 AR", d1 - k, ar_addr_q.size());
    end
    wait_done(0, 1, 0);
    n_cmp++;
    if (done_at != d1 + 6) begin n_fail++; $display("FAIL b2b_write_done: got d1+%0d required d1+6", done_at - d1); end
    n_cmp++;
    if (ar_rise_q.size() < 3 || ar_rise_q[2] != d1 + 2) begin n_fail++; $display("FAIL b2b_write_start: required ARVALID at d1+2"); end
    n_cmp++;
    if (w_data_q.size() != 1 || w_data_q[0] != {24'h0, b}) begin n_fail++; $display("FAIL b2b_wdata: got %0d beats required one beat %h", w_data_q.size(), b); end
    n_cmp++;
    if (IN_DATA !== in_mdl) begin n_fail++; $display("FAIL b2b_in_data: got %h required %h", IN_DATA, in_mdl); end
  endtask

  task automatic test_read_error();
    clear_logs();
    status_q.push_back({2'b00, 32'h1});
    rx_byte = ~in_mdl; rx_resp = 2'b10;
    start_req(1, 0, 8'h00);
    wait_done(1, 1, 1);
    n_cmp++;
    if (done_at != k + 5 || err_seen !== 1'b1) begin n_fail++; $display("FAIL rerr_flag: got done k+%0d err %b required k+5 err 1", done_at - k, err_seen); end
    n_cmp++;
    if (IN_DATA !== in_mdl) begin n_fail++; $display("FAIL rerr_in_data_held: got %h required %h", IN_DATA, in_mdl); end
    clear_logs();
    status_q.push_back({2'b00, 32'h1});
    rx_byte = 8'($urandom()); rx_resp = 2'b00;
    start_req(1, 0, 8'h00);
    wait_done(1, 1, 1);
    in_mdl = rx_byte;
    n_cmp++;
    if (err_seen !== 1'b0) begin n_fail++; $display("FAIL rerr_clean_err: got %b required 0", err_seen); end
    n_cmp++;
    if (IN_DATA !== in_mdl) begin n_fail++; $display("FAIL rerr_clean_data: got %h required %h", IN_DATA, in_mdl); end
  endtask

  task automatic test_random();
    bit rd;
    int n, mode, mx, exp_done, exp_ar, exp_w;
    logic [7:0] b;
    for (int it = 0; it < 24; it++) begin
      clear_logs();
      rd = 1'($urandom_range(0, 1)); n = $urandom_range(0, 3); mode = $urandom_range(0, 5);
      aw_delay = $urandom_range(0, 3); w_delay = $urandom_range(0, 3);
      b = 8'($urandom()); rx_byte = 8'($urandom());
      for (int j = 0; j < n; j++)
        status_q.push_back({2'b00, rd ? (32'($urandom()) & ~32'h1) : (32'($urandom()) | 32'h8)});
      if (mode == 0) status_q.push_back({2'($urandom_range(1, 3)), 32'($urandom())});
      else status_q.push_back({2'b00, rd ? (32'($urandom()) | 32'h1) : (32'($urandom()) & ~32'h8)});
      rx_resp = (mode == 1 && rd) ? 2'($urandom_range(1, 3)) : 2'b00;
      b_resp  = (mode == 1 && !rd) ? 2'($urandom_range(1, 3)) : 2'b00;
      mx = (aw_delay > w_delay) ? aw_delay : w_delay;
      exp_done = (mode == 0) ? 3 + n * (G + 2) : 5 + n * (G + 2) + (rd ? 0 : mx);
      exp_ar = n + 1 + ((rd && mode != 0) ? 1 : 0);
      exp_w = (!rd && mode != 0) ? 1 : 0;
      start_req(rd, !rd, b);
      wait_done(1, 1, 1);
      if (rd && mode >= 2) in_mdl = rx_byte;
      n_cmp++;
      if (done_at != k + exp_done) begin n_fail++; $display("FAIL rnd%0d_done: got k+%0d required k+%0d", it, done_at - k, exp_done); end
      n_cmp++;
      if (err_seen !== (mode <= 1)) begin n_fail++; $display("FAIL rnd%0d_err: got %b required %b", it, err_seen, mode <= 1); end
      n_cmp++;
      if (IN_DATA !== in_mdl) begin n_fail++; $display("FAIL rnd%0d_in_data: got %h required %h", it, IN_DATA, in_mdl); end
      n_cmp++;
      if (ar_addr_q.size() != exp_ar) begin n_fail++; $display("FAIL rnd%0d_ar_count: got %0d required %0d", it, ar_addr_q.size(), exp_ar); end
      n_cmp++;
      if (w_data_q.size() != exp_w || (exp_w == 1 && w_data_q[0] != {24'h0, b})) begin
        n_fail++; $display("FAIL rnd%0d_write: got %0d beats required %0d of %h", it, w_data_q.size(), exp_w, b);
      end
    end
    aw_delay = 0; w_delay = 0; rx_resp = 2'b00; b_resp = 2'b00;
  endtask

  task automatic test_reset_mid();
    bit seen, saw_done, saw_busy;
    clear_logs();
    status_q.push_back({2'b00, 32'h0});
    aw_delay = 50;
    start_req(0, 1, 8'hC3);
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge CLK); #1;
      if (AWVALID) begin seen = 1; break; end
    end
    n_cmp++;
    if (!seen) begin n_fail++; $display("FAIL rst_mid_awvalid: got 0 required 1 before reset"); end
    #1;
    RST_N = 0; OUT_REQ = 0;
    #1;
    n_cmp++;
    if ({AWVALID, WVALID, BUSY} !== 3'b000) begin n_fail++; $display("FAIL rst_mid_async: got %b required 000", {AWVALID, WVALID, BUSY}); end
    repeat (2) @(negedge CLK);
    #1;
    RST_N = 1; aw_delay = 0; in_mdl = 8'h00;
    saw_done = 0; saw_busy = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge CLK); #1;
      saw_done |= DONE; saw_busy |= BUSY;
    end
    n_cmp++;
    if ({saw_done, saw_busy} !== 2'b00) begin n_fail++; $display("FAIL rst_mid_quiet: got done/busy %b required 00", {saw_done, saw_busy}); end
    n_cmp++;
    if (IN_DATA !== in_mdl) begin n_fail++; $display("FAIL rst_mid_in_data: got %h required %h", IN_DATA, in_mdl); end
    clear_logs();
    status_q.push_back({2'b00, 32'h1});
    rx_byte = 8'h7E;
    start_req(1, 0, 8'h00);
    wait_done(1, 1, 1);
    in_mdl = 8'h7E;
    n_cmp++;
    if (done_at != k + 5 || IN_DATA !== in_mdl) begin n_fail++; $display("FAIL rst_mid_recover: got k+%0d %h required k+5 %h", done_at - k, IN_DATA, in_mdl); end
  endtask

  initial begin
    test_reset();
    test_read_basic();
    test_read_poll();
    test_write_delay();
    test_back_to_back();
    test_read_error();
    test_random();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
